// File: rtl/mem_main_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Transaction owner: 0-3 select an RT core, 4 is the memory controller.
  typedef logic [2:0] owner_t;

  localparam owner_t OWNER_MC = 3'd4;
  localparam int     NUM_RT   = 4;

  // One-hot RT select for an RT owner id (upper owner bit is ignored).
  function automatic logic [NUM_RT-1:0] owner_onehot(input owner_t owner);
    logic [NUM_RT-1:0] oh;
    oh = 4'b0001 << owner[1:0];
    return oh;
  endfunction

endpackage

// File: rtl/mem_main_arbiter_if.sv
// Client (RT/MC) and main-memory bus bundle seen by the arbiter.
// slave  : the arbiter's view (requests and memory completion come in).
// master : the environment's view (clients and memory drive these).
interface mem_main_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  import mem_arb_pkg::*;

  logic [NUM_RT-1:0]         rt_req;
  logic [NUM_RT-1:0]         rt_we;
  logic [NUM_RT-1:0][AW-1:0] rt_addr;
  logic [NUM_RT-1:0][DW-1:0] rt_wdata;
  logic [NUM_RT-1:0]         rt_gnt;
  logic [NUM_RT-1:0]         rt_rvalid;
  logic                      mc_req;
  logic [AW-1:0]             mc_addr;
  logic                      mc_gnt;
  logic                      mc_rvalid;
  logic [DW-1:0]             rdata;
  logic                      err;
  logic                      mem_en;
  logic                      mem_we;
  logic [AW-1:0]             mem_addr;
  logic [DW-1:0]             mem_wdata;
  logic [DW-1:0]             mem_rdata;
  logic                      mem_rdy;

  modport slave (
    input  rt_req, rt_we, rt_addr, rt_wdata, mc_req, mc_addr, mem_rdata, mem_rdy,
    output rt_gnt, rt_rvalid, mc_gnt, mc_rvalid, rdata, err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output rt_req, rt_we, rt_addr, rt_wdata, mc_req, mc_addr, mem_rdata, mem_rdy,
    input  rt_gnt, rt_rvalid, mc_gnt, mc_rvalid, rdata, err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_main_arbiter_rr_arbiter4.sv
// Four-way round-robin picker: first asserted request at or after ptr,
// wrapping 3->0. Purely combinational.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] pos_s;

  // Scan from ptr upward and keep the first hit.
  always_comb begin
    gnt   = 4'b0000;
    idx   = 2'd0;
    any   = 1'b0;
    pos_s = ptr;
    for (int k = 0; k < 4; k++) begin
      pos_s = ptr + 2'(k);
      if (!any && req[pos_s]) begin
        any        = 1'b1;
        idx        = pos_s;
        gnt[pos_s] = 1'b1;
      end else begin
        // an earlier position already won, or this one is idle
        any = any;
      end
    end
  end

endmodule

// File: rtl/mem_main_arbiter.sv
// Main-memory arbiter: shares one memory port between four RT cores and the
// MC read path, one transaction in flight. IDLE->ISSUE->WAIT->RESP->IDLE.
// The MC normally wins, but after MC_MAX consecutive MC grants with an RT
// request waiting, one RT request is served. All outputs are registered.
module mem_main_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MC_MAX  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_main_arbiter_if.slave    bus
);

  localparam int SW = (MC_MAX > 0)  ? $clog2(MC_MAX + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT)    : 1;

  // State and bookkeeping registers
  arb_state_t        state_r,     state_nxt_s;
  logic [1:0]        rr_ptr_r,    rr_ptr_nxt_s;
  logic [SW-1:0]     mc_streak_r, mc_streak_nxt_s;
  logic [TW-1:0]     tmo_cnt_r,   tmo_cnt_nxt_s;
  owner_t            owner_r,     owner_nxt_s;
  logic              we_r,        we_nxt_s;

  // Output registers
  logic [NUM_RT-1:0] rt_gnt_r,    rt_gnt_nxt_s;
  logic [NUM_RT-1:0] rt_rvalid_r, rt_rvalid_nxt_s;
  logic              mc_gnt_r,    mc_gnt_nxt_s;
  logic              mc_rvalid_r, mc_rvalid_nxt_s;
  logic [DW-1:0]     rdata_r,     rdata_nxt_s;
  logic              err_r,       err_nxt_s;
  logic              mem_en_r,    mem_en_nxt_s;
  logic              mem_we_r,    mem_we_nxt_s;
  logic [AW-1:0]     mem_addr_r,  mem_addr_nxt_s;
  logic [DW-1:0]     mem_wdata_r, mem_wdata_nxt_s;

  // Round-robin picker over the RT requests
  logic [NUM_RT-1:0] rr_gnt_s;
  logic [1:0]        rr_idx_s;
  logic              rr_any_s;
  logic              mc_win_s;
  logic              streak_full_s;

  rr_arbiter4 u_rr (
    .req (bus.rt_req),
    .ptr (rr_ptr_r),
    .gnt (rr_gnt_s),
    .idx (rr_idx_s),
    .any (rr_any_s)
  );

  // MC priority is suspended only when it has used up its streak and an RT waits.
  always_comb begin
    streak_full_s = (mc_streak_r == SW'(MC_MAX));
    mc_win_s      = bus.mc_req && !(streak_full_s && (|bus.rt_req));
  end

  // Next-state and next-output logic; holding registers keep their value by
  // default, pulses default to zero.
  always_comb begin
    state_nxt_s     = state_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    mc_streak_nxt_s = mc_streak_r;
    tmo_cnt_nxt_s   = tmo_cnt_r;
    owner_nxt_s     = owner_r;
    we_nxt_s        = we_r;
    rt_gnt_nxt_s    = {NUM_RT{1'b0}};
    rt_rvalid_nxt_s = {NUM_RT{1'b0}};
    mc_gnt_nxt_s    = 1'b0;
    mc_rvalid_nxt_s = 1'b0;
    rdata_nxt_s     = rdata_r;
    err_nxt_s       = 1'b0;
    mem_en_nxt_s    = 1'b0;
    mem_we_nxt_s    = 1'b0;
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;

    case (state_r)
      IDLE: begin
        if (mc_win_s) begin
          state_nxt_s     = ISSUE;
          owner_nxt_s     = OWNER_MC;
          we_nxt_s        = 1'b0;
          mc_gnt_nxt_s    = 1'b1;
          mem_en_nxt_s    = 1'b1;
          mem_we_nxt_s    = 1'b0;
          mem_addr_nxt_s  = bus.mc_addr;
          mem_wdata_nxt_s = {DW{1'b0}};
          mc_streak_nxt_s = streak_full_s ? mc_streak_r : mc_streak_r + SW'(1);
        end else if (rr_any_s) begin
          state_nxt_s     = ISSUE;
          owner_nxt_s     = {1'b0, rr_idx_s};
          we_nxt_s        = bus.rt_we[rr_idx_s];
          rt_gnt_nxt_s    = rr_gnt_s;
          mem_en_nxt_s    = 1'b1;
          mem_we_nxt_s    = bus.rt_we[rr_idx_s];
          mem_addr_nxt_s  = bus.rt_addr[rr_idx_s];
          mem_wdata_nxt_s = bus.rt_wdata[rr_idx_s];
          rr_ptr_nxt_s    = rr_idx_s + 2'd1;
          mc_streak_nxt_s = {SW{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end

      ISSUE: begin
        state_nxt_s   = WAIT;
        tmo_cnt_nxt_s = {TW{1'b0}};
      end

      WAIT: begin
        // A completion on the last allowed cycle still counts as success.
        if (bus.mem_rdy) begin
          state_nxt_s = RESP;
          rdata_nxt_s = we_r ? {DW{1'b0}} : bus.mem_rdata;
          err_nxt_s   = 1'b0;
          if (owner_r == OWNER_MC) begin
            mc_rvalid_nxt_s = 1'b1;
          end else begin
            rt_rvalid_nxt_s = owner_onehot(owner_r);
          end
        end else if (tmo_cnt_r == TW'(TIMEOUT - 1)) begin
          state_nxt_s = RESP;
          rdata_nxt_s = {DW{1'b0}};
          err_nxt_s   = 1'b1;
          if (owner_r == OWNER_MC) begin
            mc_rvalid_nxt_s = 1'b1;
          end else begin
            rt_rvalid_nxt_s = owner_onehot(owner_r);
          end
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + TW'(1);
        end
      end

      RESP: begin
        state_nxt_s = IDLE;
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, bookkeeping and output registers; reset drops any open transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rr_ptr_r    <= 2'd0;
      mc_streak_r <= {SW{1'b0}};
      tmo_cnt_r   <= {TW{1'b0}};
      owner_r     <= 3'd0;
      we_r        <= 1'b0;
      rt_gnt_r    <= {NUM_RT{1'b0}};
      rt_rvalid_r <= {NUM_RT{1'b0}};
      mc_gnt_r    <= 1'b0;
      mc_rvalid_r <= 1'b0;
      rdata_r     <= {DW{1'b0}};
      err_r       <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      mc_streak_r <= mc_streak_nxt_s;
      tmo_cnt_r   <= tmo_cnt_nxt_s;
      owner_r     <= owner_nxt_s;
      we_r        <= we_nxt_s;
      rt_gnt_r    <= rt_gnt_nxt_s;
      rt_rvalid_r <= rt_rvalid_nxt_s;
      mc_gnt_r    <= mc_gnt_nxt_s;
      mc_rvalid_r <= mc_rvalid_nxt_s;
      rdata_r     <= rdata_nxt_s;
      err_r       <= err_nxt_s;
      mem_en_r    <= mem_en_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
    end
  end

  assign bus.rt_gnt    = rt_gnt_r;
  assign bus.rt_rvalid = rt_rvalid_r;
  assign bus.mc_gnt    = mc_gnt_r;
  assign bus.mc_rvalid = mc_rvalid_r;
  assign bus.rdata     = rdata_r;
  assign bus.err       = err_r;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_main_arbiter.sv
// Bench for mem_main_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-timeline model of the arbiter.
module tb_mem_main_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int MC_MAX  = 4;
  localparam int TIMEOUT = 64;
  localparam int LOGN    = 256;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_main_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_main_arbiter #(.AW(AW), .DW(DW), .MC_MAX(MC_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // model: transaction timeline
  bit busy, timed, m_we;
  int g_edge, t_resp, rdy_edge, owner, rr, streak;
  logic [31:0] e_rdata, e_addr, e_wdata;
  logic [3:0]  e_rt_gnt, e_rt_rv;
  bit e_mc_gnt, e_mc_rv, e_err, e_en, e_we;

  // client-side pending requests
  bit rt_p[4], rt_w[4];
  logic [31:0] rt_a[4], rt_d[4];
  bit mc_p;
  logic [31:0] mc_a;
  bit rand_mode, hold_mc, fix_en;
  logic [3:0] hold_mask;
  logic [31:0] fix_val;
  int def_dly;
  int dly_q[$];

  // observation logs of DUT events
  int obs_who[LOGN], obs_t[LOGN], rsp_who[LOGN], rsp_t[LOGN], rsp_err[LOGN];
  logic [31:0] rsp_data[LOGN], gnt_addr[LOGN], gnt_wdata[LOGN];
  int gnt_we[LOGN];
  int n_obs, n_rsp, en_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < LOGN; i++) begin
      obs_who[i] = -1; obs_t[i] = -1; rsp_who[i] = -1; rsp_t[i] = -1; rsp_err[i] = -1;
      rsp_data[i] = 32'hxxxxxxxx; gnt_addr[i] = 32'hxxxxxxxx; gnt_wdata[i] = 32'hxxxxxxxx;
      gnt_we[i] = -1;
    end
    n_obs = 0; n_rsp = 0; en_cnt = 0;
  endtask

  task automatic drive_req();
    for (int i = 0; i < 4; i++) begin
      bus.rt_req[i]   = rt_p[i];
      bus.rt_we[i]    = rt_w[i];
      bus.rt_addr[i]  = rt_a[i];
      bus.rt_wdata[i] = rt_d[i];
    end
    bus.mc_req  = mc_p;
    bus.mc_addr = mc_a;
  endtask

  task automatic model_reset();
    busy = 1'b0; rdy_edge = -1; t_resp = -10; g_edge = -10;
    rr = 0; streak = 0; owner = 0;
    e_rdata = 32'h0; e_addr = 32'h0; e_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      rt_p[i] = 1'b0; rt_w[i] = 1'b0; rt_a[i] = 32'h0; rt_d[i] = 32'h0;
    end
    mc_p = 1'b0; mc_a = 32'h0; hold_mask = 4'h0; hold_mc = 1'b0;
    dly_q.delete();
  endtask

  task automatic post_rt(input int i, input bit we, input logic [31:0] a, input logic [31:0] d);
    rt_p[i] = 1'b1; rt_w[i] = we; rt_a[i] = a; rt_d[i] = d;
  endtask

  task automatic post_mc(input logic [31:0] a);
    mc_p = 1'b1; mc_a = a;
  endtask

  function automatic int rand_dly();
    int r;
    r = $urandom_range(0, 19);
    if (r < 14) return r % 4;
    if (r < 17) return $urandom_range(4, 10);
    if (r == 17) return TIMEOUT - 1;
    return TIMEOUT + $urandom_range(0, 3);
  endfunction

  task automatic reset_check();
    chk("rst_rt_gnt",    bus.rt_gnt,    0);
    chk("rst_rt_rvalid", bus.rt_rvalid, 0);
    chk("rst_mc_gnt",    bus.mc_gnt,    0);
    chk("rst_mc_rvalid", bus.mc_rvalid, 0);
    chk("rst_rdata",     bus.rdata,     0);
    chk("rst_err",       bus.err,       0);
    chk("rst_mem_en",    bus.mem_en,    0);
    chk("rst_mem_we",    bus.mem_we,    0);
    chk("rst_mem_addr",  bus.mem_addr,  0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
  endtask

  // called away from the clock edge
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    reset_check();
    model_reset();
    drive_req();
    bus.mem_rdy = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic step();
    bit anyrt, in_wait;
    int w, d, idx;
    if (rand_mode) begin
      for (int i = 0; i < 4; i++)
        if (!rt_p[i] && $urandom_range(0, 3) == 0)
          post_rt(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
      if (!mc_p && $urandom_range(0, 2) == 0) post_mc($urandom);
    end
    drive_req();
    bus.mem_rdata = fix_en ? fix_val : $urandom;
    in_wait = busy && (cyc >= g_edge + 2) && (cyc <= t_resp);
    bus.mem_rdy = in_wait ? (cyc == rdy_edge) : 1'($urandom_range(0, 1));

    e_rt_gnt = 4'h0; e_rt_rv = 4'h0; e_mc_gnt = 1'b0; e_mc_rv = 1'b0;
    e_err = 1'b0; e_en = 1'b0; e_we = 1'b0;
    if (busy && cyc == t_resp) begin
      if (owner == 4) e_mc_rv = 1'b1;
      else e_rt_rv = 4'(1 << owner);
      e_err   = timed;
      e_rdata = (timed || m_we) ? 32'h0 : bus.mem_rdata;
    end
    if (!busy) begin
      anyrt = rt_p[0] | rt_p[1] | rt_p[2] | rt_p[3];
      w = -1;
      if (mc_p && !(streak == MC_MAX && anyrt)) begin
        w = 4; owner = 4; e_mc_gnt = 1'b1; m_we = 1'b0;
        e_addr = mc_a; e_wdata = 32'h0;
        streak = (streak < MC_MAX) ? streak + 1 : MC_MAX;
        mc_p = hold_mc;
      end else if (anyrt) begin
        for (int k = 0; k < 4; k++) begin
          idx = (rr + k) % 4;
          if (w < 0 && rt_p[idx]) w = idx;
        end
        owner = w; e_rt_gnt = 4'(1 << w); m_we = rt_w[w];
        e_addr = rt_a[w]; e_wdata = rt_d[w];
        rr = (w + 1) % 4; streak = 0;
        rt_p[w] = hold_mask[w];
      end
      if (w >= 0) begin
        e_en = 1'b1; e_we = m_we; busy = 1'b1; g_edge = cyc;
        if (dly_q.size() > 0) d = dly_q.pop_front();
        else if (def_dly >= 0) d = def_dly;
        else d = rand_dly();
        if (d < TIMEOUT) begin
          timed = 1'b0; t_resp = cyc + 2 + d; rdy_edge = t_resp;
        end else begin
          timed = 1'b1; t_resp = cyc + 1 + TIMEOUT; rdy_edge = -1;
        end
      end
    end else if (cyc == t_resp + 1) begin
      busy = 1'b0;
    end

    @(posedge clk); #1;

    chk("rt_gnt",    bus.rt_gnt,    e_rt_gnt);
    chk("mc_gnt",    bus.mc_gnt,    e_mc_gnt);
    chk("rt_rvalid", bus.rt_rvalid, e_rt_rv);
    chk("mc_rvalid", bus.mc_rvalid, e_mc_rv);
    chk("rdata",     bus.rdata,     e_rdata);
    chk("err",       bus.err,       e_err);
    chk("mem_en",    bus.mem_en,    e_en);
    chk("mem_we",    bus.mem_we,    e_we);
    chk("mem_addr",  bus.mem_addr,  e_addr);
    chk("mem_wdata", bus.mem_wdata, e_wdata);

    for (int i = 0; i < 5; i++) begin
      if ((i == 4) ? bus.mc_gnt : bus.rt_gnt[i]) begin
        if (n_obs < LOGN) begin
          obs_who[n_obs] = i; obs_t[n_obs] = cyc; gnt_we[n_obs] = int'(bus.mem_we);
          gnt_addr[n_obs] = bus.mem_addr; gnt_wdata[n_obs] = bus.mem_wdata;
        end
        n_obs++;
      end
      if ((i == 4) ? bus.mc_rvalid : bus.rt_rvalid[i]) begin
        if (n_rsp < LOGN) begin
          rsp_who[n_rsp] = i; rsp_t[n_rsp] = cyc; rsp_err[n_rsp] = int'(bus.err);
          rsp_data[n_rsp] = bus.rdata;
        end
        n_rsp++;
      end
    end
    if (bus.mem_en) en_cnt++;
    cyc++;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic run_grants(input int n, input int budget);
    int k;
    k = 0;
    while (n_obs < n && k < budget) begin
      step();
      k++;
    end
    chk("grant_budget", (n_obs >= n) ? 1 : 0, 1);
  endtask

  int c0;
  int rr_exp[5] = '{0, 1, 2, 3, 0};
  int mc_exp[10] = '{4, 4, 4, 4, 0, 4, 4, 4, 4, 0};

  initial begin
    model_reset();
    clear_logs();
    rand_mode = 1'b0; fix_en = 1'b0; fix_val = 32'h0; def_dly = -1;
    drive_req();
    bus.mem_rdata = 32'h0;
    bus.mem_rdy   = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 reset_check();
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b1;

    // RT1 read, completion after two WAIT cycles
    clear_logs();
    fix_en = 1'b1; fix_val = 32'hDEADBEEF;
    dly_q.push_back(2);
    post_rt(1, 1'b0, 32'h10, 32'h0);
    c0 = cyc;
    run_cycles(8);
    chk("t1_n_gnt",    n_obs, 1);
    chk("t1_gnt_who",  obs_who[0], 1);
    chk("t1_gnt_lat",  obs_t[0] - c0 + 1, 1);
    chk("t1_addr",     gnt_addr[0], 32'h10);
    chk("t1_rsp_who",  rsp_who[0], 1);
    chk("t1_rsp_dly",  rsp_t[0] - obs_t[0], 4);
    chk("t1_rdata",    rsp_data[0], 32'hDEADBEEF);
    chk("t1_err",      rsp_err[0], 0);

    // RT3 write: one strobe, ack with zero data
    clear_logs();
    fix_val = 32'hA5A5A5A5;
    dly_q.push_back(1);
    post_rt(3, 1'b1, 32'h20, 32'h55);
    run_cycles(8);
    chk("wr_gnt_who",  obs_who[0], 3);
    chk("wr_mem_we",   gnt_we[0], 1);
    chk("wr_addr",     gnt_addr[0], 32'h20);
    chk("wr_wdata",    gnt_wdata[0], 32'h55);
    chk("wr_en_cnt",   en_cnt, 1);
    chk("wr_rsp_who",  rsp_who[0], 3);
    chk("wr_rdata",    rsp_data[0], 32'h0);
    chk("wr_err",      rsp_err[0], 0);

    // reset while an RT2 read waits: no response, later requests served
    clear_logs();
    fix_en = 1'b0;
    dly_q.push_back(20);
    post_rt(2, 1'b0, 32'h30, 32'h0);
    run_cycles(4);
    chk("mid_gnt_who", obs_who[0], 2);
    do_reset();
    clear_logs();
    run_cycles(30);
    chk("mid_no_rsp", n_rsp, 0);
    clear_logs();
    dly_q.push_back(0);
    post_rt(0, 1'b0, 32'h40, 32'h0);
    c0 = cyc;
    run_cycles(6);
    chk("post_gnt_who", obs_who[0], 0);
    chk("post_gnt_t",   obs_t[0] - c0, 0);
    chk("post_rsp_who", rsp_who[0], 0);

    // all four RT requests held, immediate completion
    do_reset();
    clear_logs();
    def_dly = 0; hold_mask = 4'hF;
    for (int i = 0; i < 4; i++) post_rt(i, 1'b0, 32'h100 + 32'(i), 32'h0);
    run_grants(5, 40);
    for (int i = 0; i < 4; i++) rt_p[i] = 1'b0;
    hold_mask = 4'h0;
    run_cycles(6);
    for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), obs_who[k], rr_exp[k]);
    for (int k = 1; k < 5; k++) chk($sformatf("rr_gap%0d", k), obs_t[k] - obs_t[k-1], 4);

    // MC and RT0 both held: MC streak of four, then one RT0
    do_reset();
    clear_logs();
    def_dly = 0; hold_mask = 4'h1; hold_mc = 1'b1;
    post_rt(0, 1'b0, 32'h200, 32'h0);
    post_mc(32'h300);
    run_grants(10, 80);
    rt_p[0] = 1'b0; mc_p = 1'b0; hold_mask = 4'h0; hold_mc = 1'b0;
    run_cycles(6);
    for (int k = 0; k < 10; k++) chk($sformatf("mc_order%0d", k), obs_who[k], mc_exp[k]);

    // MC read that never completes -> error after 64 WAIT cycles
    clear_logs();
    def_dly = -1; fix_en = 1'b1; fix_val = 32'h12345678;
    dly_q.push_back(200);
    post_mc(32'h80);
    run_cycles(70);
    chk("tmo_rsp_who", rsp_who[0], 4);
    chk("tmo_err",     rsp_err[0], 1);
    chk("tmo_rdata",   rsp_data[0], 32'h0);
    chk("tmo_waits",   rsp_t[0] - (obs_t[0] + 1), TIMEOUT);

    // completion on the last WAIT cycle is a normal response
    clear_logs();
    dly_q.push_back(TIMEOUT - 1);
    post_mc(32'h84);
    run_cycles(70);
    chk("last_rsp_who", rsp_who[0], 4);
    chk("last_err",     rsp_err[0], 0);
    chk("last_rdata",   rsp_data[0], 32'h12345678);
    chk("last_waits",   rsp_t[0] - (obs_t[0] + 1), TIMEOUT);

    // random traffic, then drain
    fix_en = 1'b0; def_dly = -1; rand_mode = 1'b1;
    run_cycles(500);
    rand_mode = 1'b0;
    run_cycles(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
